// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/adder.sv
// One-bit full-adder cell with per-bit generate/propagate; purely combinational.
module adder (
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o,
    output logic g_o,
    output logic p_o
);

    // Propagate is the XOR form so group P means "carry-in passes straight through".
    assign g_o     = a_i & b_i;
    assign p_o     = a_i ^ b_i;
    assign sum_o   = p_o ^ carry_i;
    assign carry_o = g_o | (p_o & carry_i);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: accepts operands in IDLE, runs WIDTH cycles LSB first through
// one adder cell, then holds sum/carry/group G/P in DONE until the result is taken.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             G_o,
    output logic             P_o,
    output logic             valid_o,
    input  logic             ready_i
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sa_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic             g_acc_q, g_acc_d;
    logic             p_acc_q, p_acc_d;
    logic             cin_q, cin_d;

    logic cell_sum, cell_carry, cell_g, cell_p;

    adder u_cell (
        .a_i     (a_sh_q[0]),
        .b_i     (b_sh_q[0]),
        .carry_i (carry_q),
        .sum_o   (cell_sum),
        .carry_o (cell_carry),
        .g_o     (cell_g),
        .p_o     (cell_p)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            g_acc_q  <= 1'b0;
            p_acc_q  <= 1'b1;
            cin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            g_acc_q  <= g_acc_d;
            p_acc_q  <= p_acc_d;
            cin_q    <= cin_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        g_acc_d  = g_acc_q;
        p_acc_d  = p_acc_q;
        cin_d    = cin_q;
        ready_o  = 1'b0;
        valid_o  = 1'b0;
        sum_o    = '0;
        carry_o  = 1'b0;
        G_o      = 1'b0;
        P_o      = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    a_sh_d   = a_i;
                    b_sh_d   = b_i;
                    carry_d  = carry_i;
                    cin_d    = carry_i;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    g_acc_d  = 1'b0;
                    p_acc_d  = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(cell_sum) << (WIDTH - 1));
                carry_d  = cell_carry;
                g_acc_d  = cell_g | (cell_p & g_acc_q);
                p_acc_d  = p_acc_q & cell_p;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                sum_o   = sum_sh_q;
                carry_o = carry_q;
                G_o     = g_acc_q;
                P_o     = p_acc_q;
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    a_carry_gp : assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == DONE) |-> (carry_o == (G_o | (P_o & cin_q))));

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       cin8 = 1'b0, vi8 = 1'b0, ro8, co8, g8, p8, vo8, ri8 = 1'b0;

    logic       a1 = 1'b0, b1 = 1'b0, sum1;
    logic       cin1 = 1'b0, vi1 = 1'b0, ro1, co1, g1, p1, vo1, ri1 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .a_i(a8), .b_i(b8), .carry_i(cin8), .valid_i(vi8),
        .ready_o(ro8), .sum_o(sum8), .carry_o(co8), .G_o(g8), .P_o(p8),
        .valid_o(vo8), .ready_i(ri8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .a_i(a1), .b_i(b1), .carry_i(cin1), .valid_i(vi1),
        .ready_o(ro1), .sum_o(sum1), .carry_o(co1), .G_o(g1), .P_o(p1),
        .valid_o(vo1), .ready_i(ri1)
    );

    // Present one operand pair, let it be accepted, wait for valid_o; lat = edges after accept.
    task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                             output int lat);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; vi8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vi8 = 1'b0;
        lat = 0;
        while (!vo8 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (!vo8) begin
            errors++;
            $display("FAIL start_op8 timeout: valid_o=%0b required 1 after %0d cycles", vo8, lat);
        end
    endtask

    task automatic finish_op8;
        ri8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ri8 = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({ro8, vo8, sum8, co8, g8, p8} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset8: ready=%0b valid=%0b sum=%h c=%0b G=%0b P=%0b required 1 0 00 0 0 0",
                     ro8, vo8, sum8, co8, g8, p8);
        end
        checks++;
        if ({ro1, vo1, sum1, co1, g1, p1} !== 6'b100000) begin
            errors++;
            $display("FAIL reset1: ready=%0b valid=%0b sum=%0b c=%0b G=%0b P=%0b required 1 0 0 0 0 0",
                     ro1, vo1, sum1, co1, g1, p1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_generate;
        int lat;
        start_op8(8'hFF, 8'h01, 1'b0, lat);
        checks++;
        if ({co8, sum8, g8, p8} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL generate: c=%0b sum=%h G=%0b P=%0b required 1 00 1 0", co8, sum8, g8, p8);
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL latency: got %0d cycles required 8", lat);
        end
        finish_op8();
        checks++;
        if ({vo8, ro8, sum8} !== {1'b0, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL release: valid=%0b ready=%0b sum=%h required 0 1 00", vo8, ro8, sum8);
        end
    endtask

    task automatic test_ripple;
        int lat;
        start_op8(8'h0F, 8'hF0, 1'b1, lat);
        checks++;
        if ({co8, sum8, g8, p8} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL ripple: c=%0b sum=%h G=%0b P=%0b required 1 00 0 1", co8, sum8, g8, p8);
        end
        finish_op8();
    endtask

    task automatic test_backpressure;
        int lat;
        start_op8(8'h12, 8'h34, 1'b0, lat);
        ri8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({vo8, ro8, sum8, co8} !== {1'b1, 1'b0, 8'h46, 1'b0}) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%0b ready=%0b sum=%h c=%0b required 1 0 46 0",
                         i, vo8, ro8, sum8, co8);
            end
            @(negedge clk);
        end
        finish_op8();
        checks++;
        if ({vo8, ro8} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: valid=%0b ready=%0b required 0 1", vo8, ro8);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; vi8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vi8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ro8, vo8, sum8} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_mid: ready=%0b valid=%0b sum=%h required 1 0 00", ro8, vo8, sum8);
        end
        @(negedge clk);
        rst = 1'b0;
        start_op8(8'h80, 8'h80, 1'b0, lat);
        checks++;
        if ({co8, sum8, g8, p8, lat[7:0]} !== {1'b1, 8'h00, 1'b1, 1'b0, 8'd8}) begin
            errors++;
            $display("FAIL after_reset: c=%0b sum=%h G=%0b P=%0b lat=%0d required 1 00 1 0 8",
                     co8, sum8, g8, p8, lat);
        end
        finish_op8();
    endtask

    task automatic test_perturb;
        int cyc;
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1; vi8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc = 0;
        while (!vo8 && cyc < 40) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); vi8 = 1'($urandom);
            checks++;
            if (ro8 !== 1'b0) begin
                errors++;
                $display("FAIL perturb_ready[%0d]: ready=%0b required 0", cyc, ro8);
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        vi8 = 1'b0;
        // 0x5A + 0xC3 + 1 = 0x11E; group G from 0x5A+0xC3 overflowing, P = &(0x99) = 0
        checks++;
        if ({vo8, co8, sum8, g8, p8} !== {1'b1, 1'b1, 8'h1E, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL perturb: valid=%0b c=%0b sum=%h G=%0b P=%0b required 1 1 1e 1 0",
                     vo8, co8, sum8, g8, p8);
        end
        finish_op8();
    endtask

    task automatic test_random_w8;
        logic [7:0] a, b;
        logic       c, eg, ep;
        logic [8:0] full, ab;
        int         lat, hold;
        for (int n = 0; n < 100; n++) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            hold = $urandom_range(0, 3);
            full = {1'b0, a} + {1'b0, b} + {8'b0, c};
            ab   = {1'b0, a} + {1'b0, b};
            eg   = ab[8];
            ep   = &(a ^ b);
            start_op8(a, b, c, lat);
            repeat (hold) @(negedge clk);
            checks++;
            if ({co8, sum8, g8, p8, lat[7:0]} !== {full, eg, ep, 8'd8}) begin
                errors++;
                $display("FAIL rand8[%0d] a=%h b=%h cin=%0b: got c=%0b sum=%h G=%0b P=%0b lat=%0d required %0b %h %0b %0b 8",
                         n, a, b, c, co8, sum8, g8, p8, lat, full[8], full[7:0], eg, ep);
            end
            finish_op8();
        end
    endtask

    task automatic test_random_w1;
        logic a, b, c;
        logic [1:0] full;
        int lat, hold;
        for (int n = 0; n < 100; n++) begin
            a = 1'($urandom); b = 1'($urandom); c = 1'($urandom);
            hold = $urandom_range(0, 3);
            full = {1'b0, a} + {1'b0, b} + {1'b0, c};
            @(negedge clk);
            a1 = a; b1 = b; cin1 = c; vi1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            vi1 = 1'b0;
            lat = 0;
            while (!vo1 && lat < 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            repeat (hold) @(negedge clk);
            checks++;
            if ({vo1, co1, sum1, g1, p1, lat[3:0]} !== {1'b1, full, a & b, a ^ b, 4'd1}) begin
                errors++;
                $display("FAIL rand1[%0d] a=%0b b=%0b cin=%0b: got v=%0b c=%0b s=%0b G=%0b P=%0b lat=%0d required 1 %0b %0b %0b %0b 1",
                         n, a, b, c, vo1, co1, sum1, g1, p1, lat, full[1], full[0], a & b, a ^ b);
            end
            ri1 = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ri1 = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_generate();
        test_ripple();
        test_backpressure();
        test_reset_mid();
        test_perturb();
        test_random_w8();
        test_random_w1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
